// File: rtl/input_word_deserializer.sv
// Multi-lane serial-to-parallel input deserializer.
// Each lane shifts in one bit per qualified strobe; after WORD_WIDTH bits the
// assembled word moves into a one-deep holding register offered to a
// valid/ready consumer, while the next word accumulates behind it.
module input_word_deserializer #(
  parameter  int LANES      = 4,
  parameter  int WORD_WIDTH = 8,
  localparam int CNT_W      = $clog2(WORD_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 async_rst_n,
  input  logic                                 clk_en,
  input  logic                                 sample_en_i,
  input  logic                                 clear_en_i,
  input  logic                                 bit_order_i,
  input  logic [LANES-1:0]                     data_i,
  output logic [LANES-1:0][WORD_WIDTH-1:0]     word_o,
  output logic                                 word_valid_o,
  input  logic                                 word_ready_i,
  output logic [CNT_W-1:0]                     bit_count_o,
  output logic                                 overrun_o,
  input  logic                                 overrun_clr_i
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  // Registered state (stage p0)
  logic [LANES-1:0][WORD_WIDTH-1:0] shift_p0;
  logic [CNT_W-1:0]                 cnt_p0;
  logic                             lsb_mode_p0;
  logic [LANES-1:0][WORD_WIDTH-1:0] word_p0;
  logic                             vld_p0;
  logic                             ovr_p0;

  // Next-state values
  logic [LANES-1:0][WORD_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]                 cnt_nxt;
  logic                             lsb_mode_nxt;
  logic [LANES-1:0][WORD_WIDTH-1:0] word_nxt;
  logic                             vld_nxt;
  logic                             ovr_nxt;

  // Decoded events
  logic                             clear;
  logic                             sample;
  logic                             first_bit;
  logic                             lsb_eff;
  logic                             complete;
  logic                             handshake;
  logic                             load;
  logic                             drop;
  logic [LANES-1:0][WORD_WIDTH-1:0] assembled;

  // Shift one bit into a lane in the selected order.
  function automatic logic [WORD_WIDTH-1:0] shift_in(
    input logic [WORD_WIDTH-1:0] cur,
    input logic                  bit_in,
    input logic                  lsb_first
  );
    if (lsb_first)
      return {bit_in, cur[WORD_WIDTH-1:1]};
    else
      return {cur[WORD_WIDTH-2:0], bit_in};
  endfunction

  // Decode strobes, handshake and completion for this cycle.
  always_comb begin
    clear     = clk_en && clear_en_i;
    sample    = clk_en && sample_en_i && !clear_en_i;
    first_bit = (cnt_p0 == '0);
    // Bit order is only honoured on the first bit of a word.
    lsb_eff   = first_bit ? bit_order_i : lsb_mode_p0;
    complete  = sample && (cnt_p0 == LAST_BIT);
    handshake = vld_p0 && word_ready_i && clk_en;
    load      = complete && (!vld_p0 || handshake);
    drop      = complete && !load;
    for (int l = 0; l < LANES; l++) begin
      assembled[l] = shift_in(shift_p0[l], data_i[l], lsb_eff);
    end
  end

  // Next-state logic for shifter, counter, holding register and overrun flag.
  always_comb begin
    shift_nxt    = shift_p0;
    cnt_nxt      = cnt_p0;
    lsb_mode_nxt = lsb_mode_p0;
    word_nxt     = word_p0;
    vld_nxt      = vld_p0;
    ovr_nxt      = ovr_p0;

    if (clear) begin
      shift_nxt = '0;
      cnt_nxt   = '0;
    end else if (sample) begin
      shift_nxt    = assembled;
      lsb_mode_nxt = lsb_eff;
      // Counter wraps on completion so WORD_WIDTH is never shown.
      cnt_nxt      = complete ? '0 : cnt_p0 + CNT_W'(1);
    end

    if (handshake)
      vld_nxt = 1'b0;
    // A completion in the same cycle as a drain refills the holder.
    if (load) begin
      word_nxt = assembled;
      vld_nxt  = 1'b1;
    end

    if (clk_en && overrun_clr_i)
      ovr_nxt = 1'b0;
    // Setting takes priority over a simultaneous clear.
    if (drop)
      ovr_nxt = 1'b1;
  end

  // State registers; everything holds while clk_en is low.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      shift_p0    <= '0;
      cnt_p0      <= '0;
      lsb_mode_p0 <= 1'b0;
      word_p0     <= '0;
      vld_p0      <= 1'b0;
      ovr_p0      <= 1'b0;
    end else begin
      shift_p0    <= shift_nxt;
      cnt_p0      <= cnt_nxt;
      lsb_mode_p0 <= lsb_mode_nxt;
      word_p0     <= word_nxt;
      vld_p0      <= vld_nxt;
      ovr_p0      <= ovr_nxt;
    end
  end

  assign word_o       = word_p0;
  assign word_valid_o = vld_p0;
  assign bit_count_o  = cnt_p0;
  assign overrun_o    = ovr_p0;

endmodule

// File: tb/tb_input_word_deserializer.sv
// Directed bench for input_word_deserializer with LANES=2, WORD_WIDTH=4.
module tb_input_word_deserializer;

  localparam int LANES = 2;
  localparam int WW    = 4;
  localparam int CW    = 2;

  logic                       clk = 1'b0;
  logic                       async_rst_n;
  logic                       clk_en;
  logic                       sample_en_i;
  logic                       clear_en_i;
  logic                       bit_order_i;
  logic [LANES-1:0]           data_i;
  logic [LANES-1:0][WW-1:0]   word_o;
  logic                       word_valid_o;
  logic                       word_ready_i;
  logic [CW-1:0]              bit_count_o;
  logic                       overrun_o;
  logic                       overrun_clr_i;

  int n_checks = 0;
  int n_pass   = 0;

  input_word_deserializer #(.LANES(LANES), .WORD_WIDTH(WW)) dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
    .sample_en_i  (sample_en_i),
    .clear_en_i   (clear_en_i),
    .bit_order_i  (bit_order_i),
    .data_i       (data_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .bit_count_o  (bit_count_o),
    .overrun_o    (overrun_o),
    .overrun_clr_i(overrun_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one bit per lane as a sample.
  task automatic send_bit(input logic [1:0] d, input logic ord);
    sample_en_i = 1'b1;
    data_i      = d;
    bit_order_i = ord;
    tick();
    sample_en_i = 1'b0;
  endtask

  // Send a 4-bit sequence per lane, first-arriving bit at index 3.
  // ord is the order on the first bit; later bits use ord^flip.
  // rdy_last drives word_ready_i during the final sample only.
  task automatic send_word(input logic [3:0] l0, input logic [3:0] l1,
                           input logic ord, input logic flip, input logic rdy_last);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) word_ready_i = rdy_last;
      send_bit({l1[i], l0[i]}, (i == 3) ? ord : (ord ^ flip));
      word_ready_i = 1'b0;
    end
  endtask

  task automatic drain();
    word_ready_i = 1'b1;
    tick();
    word_ready_i = 1'b0;
  endtask

  initial begin
    async_rst_n   = 1'b0;
    clk_en        = 1'b1;
    sample_en_i   = 1'b0;
    clear_en_i    = 1'b0;
    bit_order_i   = 1'b0;
    data_i        = '0;
    word_ready_i  = 1'b0;
    overrun_clr_i = 1'b0;
    #12;
    check("rst_word",  32'(word_o),       32'h00);
    check("rst_valid", 32'(word_valid_o), 32'd0);
    check("rst_cnt",   32'(bit_count_o),  32'd0);
    check("rst_ovr",   32'(overrun_o),    32'd0);
    #3 async_rst_n = 1'b1;
    tick();

    // 1: MSB-first
    send_bit(2'b01, 1'b0);
    send_bit(2'b10, 1'b0);
    check("msb_cnt2", 32'(bit_count_o), 32'd2);
    send_bit(2'b11, 1'b0);
    send_bit(2'b01, 1'b0);
    check("msb_valid", 32'(word_valid_o), 32'd1);
    check("msb_word",  32'(word_o),       32'h6B);
    check("msb_cnt0",  32'(bit_count_o),  32'd0);
    drain();
    check("msb_drained", 32'(word_valid_o), 32'd0);

    // 2: LSB-first with bit_order toggled after the first bit
    send_word(4'b1011, 4'b0110, 1'b1, 1'b1, 1'b0);
    check("lsb_valid", 32'(word_valid_o), 32'd1);
    check("lsb_word",  32'(word_o),       32'h6D);
    drain();

    // 3: backpressure overrun
    send_word(4'b1011, 4'b0110, 1'b0, 1'b0, 1'b0);
    send_word(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("ovr_set",   32'(overrun_o),    32'd1);
    check("ovr_word",  32'(word_o),       32'h6B);
    check("ovr_valid", 32'(word_valid_o), 32'd1);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    check("ovr_clr",   32'(overrun_o),    32'd0);
    drain();
    check("ovr_drain", 32'(word_valid_o), 32'd0);

    // 4: drain and completion in the same cycle
    send_word(4'b1011, 4'b0110, 1'b0, 1'b0, 1'b0);
    send_word(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1);
    check("sim_valid", 32'(word_valid_o), 32'd1);
    check("sim_word",  32'(word_o),       32'hF4);
    check("sim_ovr",   32'(overrun_o),    32'd0);
    drain();

    // 5: flush with a coincident sample
    send_bit(2'b11, 1'b0);
    send_bit(2'b11, 1'b0);
    clear_en_i  = 1'b1;
    sample_en_i = 1'b1;
    data_i      = 2'b11;
    tick();
    clear_en_i  = 1'b0;
    sample_en_i = 1'b0;
    check("flush_cnt",   32'(bit_count_o),  32'd0);
    check("flush_valid", 32'(word_valid_o), 32'd0);
    send_word(4'b1011, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("flush_word",  32'(word_o),       32'h6B);
    drain();

    // 6: stall, then asynchronous reset mid-word
    send_bit(2'b01, 1'b0);
    send_bit(2'b10, 1'b0);
    clk_en       = 1'b0;
    sample_en_i  = 1'b1;
    word_ready_i = 1'b1;
    tick();
    tick();
    sample_en_i  = 1'b0;
    word_ready_i = 1'b0;
    check("stall_cnt",  32'(bit_count_o), 32'd2);
    check("stall_word", 32'(word_o),      32'h6B);
    clk_en = 1'b1;
    send_bit(2'b11, 1'b0);
    check("pre_rst_cnt", 32'(bit_count_o), 32'd3);
    #2 async_rst_n = 1'b0;
    #1;
    check("arst_word", 32'(word_o),       32'h00);
    check("arst_cnt",  32'(bit_count_o),  32'd0);
    check("arst_vld",  32'(word_valid_o), 32'd0);
    check("arst_ovr",  32'(overrun_o),    32'd0);
    tick();
    async_rst_n = 1'b1;
    tick();
    send_bit(2'b01, 1'b0);
    send_bit(2'b10, 1'b0);
    send_bit(2'b11, 1'b0);
    check("post_rst_3", 32'(word_valid_o), 32'd0);
    send_bit(2'b01, 1'b0);
    check("post_rst_4", 32'(word_valid_o), 32'd1);
    check("post_rst_w", 32'(word_o),       32'h6B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
